// File: rtl/bgd_mul_pkg.sv
// Shared types and defaults for the BGD multiplier-sharing controller.
// Shadow entries carry a fixed 3-bit id so any requester count up to 8 fits.
package bgd_mul_pkg;
  localparam int DATA_W  = 13;
  localparam int ID_W    = 2;
  localparam int MAX_REQ = 8;
  localparam int SH_ID_W = 3;

  typedef struct packed {
    logic               valid;
    logic [SH_ID_W-1:0] id;
  } shadow_t;

  function automatic logic [MAX_REQ-1:0] id_to_onehot(input logic [SH_ID_W-1:0] id);
    id_to_onehot     = '0;
    id_to_onehot[id] = 1'b1;
  endfunction
endpackage

// File: rtl/bgd_mul_share_ctrl_if.sv
// Requester and result handshake bundle for the shared-multiplier controller.
// Handshake rule: a beat transfers on a clock edge where valid & ready are both high.
interface bgd_mul_share_ctrl_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = bgd_mul_pkg::DATA_W,
  parameter int ID_W    = bgd_mul_pkg::ID_W
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic                      res_valid;
  logic                      res_ready;
  logic [DATA_W-1:0]         res_data;
  logic [ID_W-1:0]           res_id;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_data, res_id
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_data, res_id
  );
endinterface

// File: rtl/bgd_rr_arbiter.sv
// Round-robin arbiter: searches upward from the pointer, wrapping to 0.
// The pointer moves past the winner only when the grant is actually taken.
module bgd_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] cidx;
  logic             found;
  int               cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    cidx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cidx = IDX_W'(cand);
      if (!found && req[cidx]) begin
        found       = 1'b1;
        grant[cidx] = 1'b1;
        idx         = cidx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (int'(idx) == NUM_REQ - 1) ? '0 : idx + IDX_W'(1);
    end
  end
endmodule

// File: rtl/bgd_mul_share_ctrl.sv
// Shares one pipelined, ce-stalled 13x13 multiplier among NUM_REQ requesters,
// tracking in-flight ids in a shadow pipeline that mirrors the multiplier.
module bgd_mul_share_ctrl #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = bgd_mul_pkg::DATA_W,
  parameter int MUL_LAT = 3,
  parameter int ID_W    = bgd_mul_pkg::ID_W
) (
  input  logic                           clk,
  input  logic                           reset,
  bgd_mul_share_ctrl_if.slave            bus,
  output logic                           mul_ce,
  output logic [DATA_W-1:0]              mul_din0,
  output logic [DATA_W-1:0]              mul_din1,
  input  logic [DATA_W-1:0]              mul_dout,
  output logic [$clog2(MUL_LAT+1)-1:0]   inflight
);
  import bgd_mul_pkg::*;

  localparam int CNT_W = $clog2(MUL_LAT + 1);

  logic               stall, xfer, res_hs, any_req;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    win_idx;
  logic [DATA_W-1:0]  win_a, win_b, hold_a, hold_b;
  shadow_t            sh [MUL_LAT];

  // A waiting result freezes the whole pipe, multiplier included.
  assign stall         = bus.res_valid & ~bus.res_ready;
  assign mul_ce        = ~stall;
  assign any_req       = |grant;
  assign xfer          = mul_ce & any_req;
  assign res_hs        = bus.res_valid & bus.res_ready;
  assign bus.req_ready = grant & {NUM_REQ{mul_ce}};

  bgd_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (ID_W)
  ) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (bus.req_valid),
    .advance (xfer),
    .grant   (grant),
    .idx     (win_idx)
  );

  assign win_a = bus.req_a[int'(win_idx)*DATA_W +: DATA_W];
  assign win_b = bus.req_b[int'(win_idx)*DATA_W +: DATA_W];

  // Idle cycles replay the last granted operands so the DSP inputs stay quiet.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_a <= '0;
      hold_b <= '0;
    end else if (xfer) begin
      hold_a <= win_a;
      hold_b <= win_b;
    end
  end

  assign mul_din0 = any_req ? win_a : hold_a;
  assign mul_din1 = any_req ? win_b : hold_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MUL_LAT; i++) sh[i] <= '0;
    end else if (mul_ce) begin
      sh[0].valid <= xfer;
      sh[0].id    <= SH_ID_W'(win_idx);
      for (int i = 1; i < MUL_LAT; i++) sh[i] <= sh[i-1];
    end
  end

  assign bus.res_valid = sh[MUL_LAT-1].valid;
  assign bus.res_id    = ID_W'(sh[MUL_LAT-1].id);
  assign bus.res_data  = mul_dout;

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight <= '0;
    end else begin
      case ({xfer, res_hs})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end
endmodule

// File: tb/tb_bgd_mul_share_ctrl.sv
// Directed bench for bgd_mul_share_ctrl with a behavioural 3-stage ce-stalled multiplier.
module tb_bgd_mul_share_ctrl;
  import bgd_mul_pkg::*;

  localparam int NR  = 4;
  localparam int DW  = 13;
  localparam int IW  = 2;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          mul_ce;
  logic [DW-1:0] mul_din0, mul_din1, mul_dout;
  logic [1:0]    inflight;
  logic [DW-1:0] p0, p1, p2;
  logic [MAX_REQ-1:0] exp_oh;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bgd_mul_share_ctrl_if #(.NUM_REQ(NR), .DATA_W(DW), .ID_W(IW)) bus ();

  bgd_mul_share_ctrl #(
    .NUM_REQ (NR),
    .DATA_W  (DW),
    .MUL_LAT (LAT),
    .ID_W    (IW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .mul_ce   (mul_ce),
    .mul_din0 (mul_din0),
    .mul_din1 (mul_din1),
    .mul_dout (mul_dout),
    .inflight (inflight)
  );

  // Shared DSP stand-in: three registers, all gated by ce, no reset.
  always @(posedge clk) begin
    if (mul_ce) begin
      p0 <= DW'($signed(mul_din0) * $signed(mul_din1));
      p1 <= p0;
      p2 <= p1;
    end
  end
  assign mul_dout = p2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    bus.req_a[i*DW +: DW] = a;
    bus.req_b[i*DW +: DW] = b;
  endtask

  task automatic chk_res(input string tag, input logic [DW-1:0] data, input logic [IW-1:0] id);
    chk({tag, "_valid"}, 32'(bus.res_valid), 32'd1);
    chk({tag, "_data"},  32'(bus.res_data),  32'(data));
    chk({tag, "_id"},    32'(bus.res_id),    32'(id));
  endtask

  initial begin
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.res_ready = 1'b1;
    repeat (2) next();
    reset = 1'b0;
    mid();
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_inflight",  32'(inflight),      32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_mul_ce",    32'(mul_ce),        32'd1);
    chk("rst_res_id",    32'(bus.res_id),    32'd0);

    // Single op: 3 * -5 = -15
    next(); set_op(0, 13'd3, 13'h1FFB); bus.req_valid = 4'b0001;
    mid();
    chk("single_ready", 32'(bus.req_ready), 32'h1);
    chk("single_din0",  32'(mul_din0),      32'h3);
    chk("single_din1",  32'(mul_din1),      32'h1FFB);
    next(); bus.req_valid = 4'b0000;
    mid();
    chk("single_infl1",  32'(inflight),      32'd1);
    chk("single_nores1", 32'(bus.res_valid), 32'd0);
    chk("hold_din0",     32'(mul_din0),      32'h3);
    chk("hold_din1",     32'(mul_din1),      32'h1FFB);
    next(); mid();
    chk("single_nores2", 32'(bus.res_valid), 32'd0);
    next(); mid();
    chk_res("single", 13'h1FF1, 2'd0);
    next(); mid();
    chk("single_done_valid", 32'(bus.res_valid), 32'd0);
    chk("single_done_infl",  32'(inflight),      32'd0);

    // Wrap: 100*100 = 10000 mod 8192, then -4096*2 wraps to 0
    next(); set_op(2, 13'd100, 13'd100); bus.req_valid = 4'b0100;
    mid();
    chk("wrap_ready0", 32'(bus.req_ready), 32'h4);
    next(); set_op(2, 13'h1000, 13'd2);
    mid();
    chk("wrap_ready1", 32'(bus.req_ready), 32'h4);
    chk("wrap_infl1",  32'(inflight),      32'd1);
    next(); bus.req_valid = 4'b0000;
    mid();
    chk("wrap_infl2", 32'(inflight),      32'd2);
    chk("wrap_nores", 32'(bus.res_valid), 32'd0);
    next(); mid();
    chk_res("wrap_a", 13'h0710, 2'd2);
    chk("wrap_infl_a", 32'(inflight), 32'd2);
    next(); mid();
    chk_res("wrap_b", 13'h0000, 2'd2);
    chk("wrap_infl_b", 32'(inflight), 32'd1);
    next(); mid();
    chk("wrap_done", 32'(bus.res_valid), 32'd0);

    // req3 alone: -1 * -1 = 1, moves pointer back to 0
    next(); set_op(3, 13'h1FFF, 13'h1FFF); bus.req_valid = 4'b1000;
    mid();
    chk("r3_ready", 32'(bus.req_ready), 32'h8);
    next(); bus.req_valid = 4'b0000;
    next(); next(); mid();
    chk_res("r3", 13'h0001, 2'd3);

    // Fairness: all requesters held for 8 cycles, products (i+1)*7
    for (int i = 0; i < NR; i++) set_op(i, DW'(i + 1), 13'd7);
    for (int j = 0; j < 12; j++) begin
      next();
      bus.req_valid = (j < 8) ? 4'hF : 4'h0;
      mid();
      exp_oh = (j < 8) ? id_to_onehot(3'(j % 4)) : '0;
      chk("fair_ready", 32'(bus.req_ready), 32'(exp_oh[NR-1:0]));
      if (j >= 3 && j < 11) chk_res("fair", DW'(((j - 3) % 4 + 1) * 7), IW'((j - 3) % 4));
      else                  chk("fair_idle", 32'(bus.res_valid), 32'd0);
      chk("fair_infl", 32'(inflight), 32'((j < 8 ? j : 8) - (j > 3 ? j - 3 : 0)));
    end

    // Backpressure: 3 in flight, res_ready low for 5 cycles, req3 waiting
    set_op(0, 13'd5, 13'd6);
    set_op(1, 13'h1FF9, 13'd8);
    set_op(2, 13'h1FF7, 13'h1FF7);
    set_op(3, 13'd2, 13'd3);
    for (int j = 0; j < 13; j++) begin
      next();
      bus.req_valid = (j < 3) ? 4'b0111 : ((j < 9) ? 4'b1000 : 4'b0000);
      bus.res_ready = (j >= 3 && j < 8) ? 1'b0 : 1'b1;
      mid();
      if (j < 3) begin
        exp_oh = id_to_onehot(3'(j));
        chk("bp_ready", 32'(bus.req_ready), 32'(exp_oh[NR-1:0]));
      end else if (j < 8) begin
        chk("bp_ce",    32'(mul_ce),        32'd0);
        chk("bp_ready", 32'(bus.req_ready), 32'd0);
        chk("bp_infl",  32'(inflight),      32'd3);
        chk_res("bp_hold", 13'h001E, 2'd0);
      end else if (j == 8) begin
        chk("bp_simul_ready", 32'(bus.req_ready), 32'h8);
        chk_res("bp_r0", 13'h001E, 2'd0);
      end else if (j == 9) begin
        chk_res("bp_r1", 13'h1FC8, 2'd1);
        chk("bp_simul_infl", 32'(inflight), 32'd3);
      end else if (j == 10) begin
        chk_res("bp_r2", 13'h0051, 2'd2);
        chk("bp_infl2", 32'(inflight), 32'd2);
      end else if (j == 11) begin
        chk_res("bp_r3", 13'h0006, 2'd3);
        chk("bp_infl1", 32'(inflight), 32'd1);
      end else begin
        chk("bp_drained_valid", 32'(bus.res_valid), 32'd0);
        chk("bp_drained_infl",  32'(inflight),      32'd0);
      end
    end

    // req1 raises valid during a stall and drops it before being granted
    next(); set_op(0, 13'd1, 13'd1); bus.req_valid = 4'b0001;
    mid();
    chk("drop_r0_ready", 32'(bus.req_ready), 32'h1);
    next(); bus.req_valid = 4'b0000;
    next();
    next(); bus.res_ready = 1'b0; bus.req_valid = 4'b0010;
    mid();
    chk("drop_ce",    32'(mul_ce),        32'd0);
    chk("drop_ready", 32'(bus.req_ready), 32'd0);
    chk("drop_infl",  32'(inflight),      32'd1);
    next(); bus.req_valid = 4'b0000; bus.res_ready = 1'b1;
    mid();
    chk_res("drop_res", 13'h0001, 2'd0);
    chk("drop_infl2", 32'(inflight), 32'd1);
    next(); bus.req_valid = 4'hF;
    mid();
    chk("drop_ptr_kept", 32'(bus.req_ready), 32'h2);
    chk("drop_no_entry", 32'(inflight),      32'd0);
    next(); mid();
    chk("mid_ready2", 32'(bus.req_ready), 32'h4);
    chk("mid_infl1",  32'(inflight),      32'd1);

    // Reset with two ops in flight
    next(); bus.req_valid = 4'b0000; reset = 1'b1;
    mid();
    chk("pre_rst_infl", 32'(inflight), 32'd2);
    next(); reset = 1'b0;
    mid();
    chk("post_rst_valid", 32'(bus.res_valid), 32'd0);
    chk("post_rst_infl",  32'(inflight),      32'd0);
    for (int j = 0; j < 3; j++) begin
      next(); mid();
      chk("no_stale", 32'(bus.res_valid), 32'd0);
    end
    next(); set_op(0, 13'h1FFD, 13'h1FFC); bus.req_valid = 4'hF;
    mid();
    chk("post_rst_ptr", 32'(bus.req_ready), 32'h1);
    next(); bus.req_valid = 4'b0000;
    next(); next(); mid();
    chk_res("post_rst", 13'h000C, 2'd0);
    next(); mid();
    chk("final_valid", 32'(bus.res_valid), 32'd0);
    chk("final_infl",  32'(inflight),      32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
